// File: rtl/small_int8_quantizer.sv
// rtl/small_int8_quantizer.sv - row-wise power-of-two FP16 to INT8 quantizer
//
// Buffers one row-group of ROW_BEATS beats (FILL), tracking the largest
// exponent field per row, then replays the buffered beats as signed INT8
// values with a shared per-row scale exponent (DRAIN).
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   data_in             FP16 tile, row r in elements [IN_SIZE*r +: IN_SIZE]
//   data_in_valid/ready input handshake (ready only in FILL)
//   data_out            signed INT8 tile, same layout as data_in
//   data_out_scale      signed scale exponent per row, x ~= q * 2^scale
//   data_out_valid/ready output handshake (valid only in DRAIN)

module small_int8_quantizer #(
    parameter int IN_WIDTH       = 16,
    parameter int IN_SIZE        = 4,
    parameter int IN_PARALLELISM = 1,
    parameter int ROW_BEATS      = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [IN_WIDTH-1:0]        data_in [IN_SIZE*IN_PARALLELISM],
    input  logic                       data_in_valid,
    output logic                       data_in_ready,
    output logic signed [7:0]          data_out [IN_SIZE*IN_PARALLELISM],
    output logic signed [7:0]          data_out_scale [IN_PARALLELISM],
    output logic                       data_out_valid,
    input  logic                       data_out_ready
);

    localparam int N  = IN_SIZE * IN_PARALLELISM;
    localparam int CW = (ROW_BEATS > 1) ? $clog2(ROW_BEATS) : 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(ROW_BEATS - 1);

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t              state_q;
    logic [CW-1:0]       beat_cnt_q;
    logic                ready_q;
    logic                valid_q;
    logic [IN_WIDTH-1:0] buffer_q [ROW_BEATS][N];
    logic [4:0]          emax_q   [IN_PARALLELISM];
    logic [4:0]          emax_d   [IN_PARALLELISM];
    logic [4:0]          beat_emax [IN_PARALLELISM];
    logic                in_fire;
    logic                out_fire;

    assign in_fire  = (state_q == FILL)  && ready_q && data_in_valid;
    assign out_fire = (state_q == DRAIN) && valid_q && data_out_ready;

    // Handshake outputs are forced low for the whole time rst is held,
    // not just from the first reset edge onward.
    assign data_in_ready  = ready_q && !rst;
    assign data_out_valid = valid_q && !rst;

    // Largest exponent field of each row in the incoming beat. Zero and
    // subnormal elements have E=0 and so never raise the maximum.
    always_comb begin
        for (int r = 0; r < IN_PARALLELISM; r++) begin
            beat_emax[r] = '0;
            for (int c = 0; c < IN_SIZE; c++) begin
                if (data_in[r*IN_SIZE+c][14:10] > beat_emax[r]) begin
                    beat_emax[r] = data_in[r*IN_SIZE+c][14:10];
                end
            end
        end
    end

    // Beat 0 starts a new row-group, so it replaces the running maximum.
    always_comb begin
        for (int r = 0; r < IN_PARALLELISM; r++) begin
            if (beat_cnt_q == '0 || beat_emax[r] > emax_q[r]) begin
                emax_d[r] = beat_emax[r];
            end else begin
                emax_d[r] = emax_q[r];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= FILL;
            beat_cnt_q <= '0;
            ready_q    <= 1'b0;
            valid_q    <= 1'b0;
            for (int b = 0; b < ROW_BEATS; b++) begin
                for (int i = 0; i < N; i++) begin
                    buffer_q[b][i] <= '0;
                end
            end
            for (int r = 0; r < IN_PARALLELISM; r++) begin
                emax_q[r] <= '0;
            end
        end else begin
            case (state_q)
                FILL: begin
                    ready_q <= 1'b1;
                    valid_q <= 1'b0;
                    if (in_fire) begin
                        for (int i = 0; i < N; i++) begin
                            buffer_q[beat_cnt_q][i] <= data_in[i];
                        end
                        for (int r = 0; r < IN_PARALLELISM; r++) begin
                            emax_q[r] <= emax_d[r];
                        end
                        if (beat_cnt_q == LAST_BEAT) begin
                            beat_cnt_q <= '0;
                            state_q    <= DRAIN;
                            ready_q    <= 1'b0;
                            valid_q    <= 1'b1;
                        end else begin
                            beat_cnt_q <= beat_cnt_q + CW'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (out_fire) begin
                        if (beat_cnt_q == LAST_BEAT) begin
                            beat_cnt_q <= '0;
                            state_q    <= FILL;
                            ready_q    <= 1'b1;
                            valid_q    <= 1'b0;
                        end else begin
                            beat_cnt_q <= beat_cnt_q + CW'(1);
                        end
                    end
                end
                default: begin
                    state_q    <= FILL;
                    beat_cnt_q <= '0;
                    ready_q    <= 1'b0;
                    valid_q    <= 1'b0;
                end
            endcase
        end
    end

    // The scale is Emax-21, so an element at exponent E carries
    // sig * 2^(E-25) = q * 2^(Emax-21). That leaves q = sig >> (Emax-E+4),
    // rounded half away from zero on the magnitude. Any shift of 12 or
    // more pushes the 11-bit significand, rounding bit included, fully out.
    function automatic logic signed [7:0] quantize(input logic [15:0] x,
                                                   input logic [4:0]  emax);
        logic [4:0]  e;
        logic [10:0] sig;
        logic [5:0]  s;
        logic [12:0] rnd;
        logic [12:0] mag;
        logic [6:0]  m;
        e        = x[14:10];
        sig      = {1'b1, x[9:0]};
        s        = 6'(emax) + 6'd4 - 6'(e);
        rnd      = '0;
        mag      = '0;
        m        = '0;
        quantize = '0;
        if (e != 5'd0 && s < 6'd12) begin
            rnd = {2'b00, sig} + (13'd1 << (s - 6'd1));
            mag = rnd >> s;
            m   = (mag > 13'd127) ? 7'd127 : mag[6:0];
            quantize = x[15] ? -$signed({1'b0, m}) : $signed({1'b0, m});
        end
    endfunction

    // Outputs depend only on registered buffer, emax and beat counter, so
    // they hold steady for as long as the consumer stalls.
    always_comb begin
        for (int r = 0; r < IN_PARALLELISM; r++) begin
            for (int c = 0; c < IN_SIZE; c++) begin
                data_out[r*IN_SIZE+c] = quantize(buffer_q[beat_cnt_q][r*IN_SIZE+c], emax_q[r]);
            end
            if (emax_q[r] == 5'd0) begin
                data_out_scale[r] = 8'sd0;
            end else begin
                data_out_scale[r] = $signed({3'b000, emax_q[r]}) - 8'sd21;
            end
        end
    end

endmodule

// File: tb/tb_small_int8_quantizer.sv
// tb/tb_small_int8_quantizer.sv - self-checking bench for small_int8_quantizer

module tb_small_int8_quantizer;

    localparam int RB = 2;
    localparam int SZ = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [15:0]       data_in [SZ];
    logic              data_in_valid;
    logic              data_in_ready;
    logic signed [7:0] data_out [SZ];
    logic signed [7:0] data_out_scale [1];
    logic              data_out_valid;
    logic              data_out_ready;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_data[$];
    int          exp_scale[$];

    small_int8_quantizer #(
        .IN_WIDTH(16), .IN_SIZE(SZ), .IN_PARALLELISM(1), .ROW_BEATS(RB)
    ) dut (
        .clk(clk),
        .rst(rst),
        .data_in(data_in),
        .data_in_valid(data_in_valid),
        .data_in_ready(data_in_ready),
        .data_out(data_out),
        .data_out_scale(data_out_scale),
        .data_out_valid(data_out_valid),
        .data_out_ready(data_out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Real-valued reference: value = sig * 2^(E-25), scale = Emax-21,
    // q = round-half-away(|value| / 2^scale), clipped to 127.
    function automatic int model_q(input logic [15:0] x, input int emax);
        int  e;
        int  m;
        real d;
        real mag;
        e = int'(x[14:10]);
        if (e == 0) return 0;
        d = 1.0;
        for (int k = 0; k < emax - e + 4; k++) d = d * 2.0;
        mag = real'(1024 + int'(x[9:0])) / d;
        m = $rtoi($floor(mag + 0.5));
        if (m > 127) m = 127;
        return x[15] ? -m : m;
    endfunction

    function automatic int model_scale(input int emax);
        return (emax == 0) ? 0 : emax - 21;
    endfunction

    function automatic logic [127:0] mkrow(
        input logic [15:0] a0, a1, a2, a3, b0, b1, b2, b3);
        return {b3, b2, b1, b0, a3, a2, a1, a0};
    endfunction

    task automatic push_model(input logic [127:0] row);
        int em;
        int e;
        logic [31:0] w;
        em = 0;
        for (int k = 0; k < RB*SZ; k++) begin
            e = int'(row[k*16+10 +: 5]);
            if (e > em) em = e;
        end
        for (int b = 0; b < RB; b++) begin
            for (int i = 0; i < SZ; i++) begin
                w[i*8 +: 8] = 8'(model_q(row[(b*SZ+i)*16 +: 16], em));
            end
            exp_data.push_back(w);
            exp_scale.push_back(model_scale(em));
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the last transfer.
    task automatic send_row(input logic [127:0] row, input int nbeats, input bit push);
        int n;
        for (int b = 0; b < nbeats; b++) begin
            for (int i = 0; i < SZ; i++) data_in[i] = row[(b*SZ+i)*16 +: 16];
            data_in_valid = 1'b1;
            n = 0;
            @(negedge clk);
            while (!data_in_ready && n < 200) begin
                @(negedge clk);
                n++;
            end
            if (n >= 200) check("in_ready_timeout", 0, 1);
            @(posedge clk);
            #1;
        end
        data_in_valid = 1'b0;
        if (push) push_model(row);
    endtask

    task automatic check_first(input int q0, q1, q2, q3, sc);
        @(negedge clk);
        check("latency_valid", int'(data_out_valid), 1);
        check("lit_q0", int'(data_out[0]), q0);
        check("lit_q1", int'(data_out[1]), q1);
        check("lit_q2", int'(data_out[2]), q2);
        check("lit_q3", int'(data_out[3]), q3);
        check("lit_scale", int'(data_out_scale[0]), sc);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_data.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("drain_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    // Output compare: every cycle the DUT presents data, it must match the
    // oldest outstanding model beat; a beat retires only on a transfer.
    always @(negedge clk) begin
        logic [31:0] f;
        if (!rst && data_out_valid) begin
            check("ready_in_drain", int'(data_in_ready), 0);
            if (exp_data.size() == 0) begin
                check("unexpected_output", 1, 0);
            end else begin
                f = exp_data[0];
                for (int i = 0; i < SZ; i++) begin
                    check($sformatf("model_q%0d", i), int'(data_out[i]),
                          int'($signed(f[i*8 +: 8])));
                end
                check("model_scale", int'(data_out_scale[0]), exp_scale[0]);
                if (data_out_ready) begin
                    void'(exp_data.pop_front());
                    void'(exp_scale.pop_front());
                end
            end
        end
    end

    initial begin
        data_in_valid  = 1'b0;
        data_out_ready = 1'b1;
        for (int i = 0; i < SZ; i++) data_in[i] = '0;

        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("reset_in_ready", int'(data_in_ready), 0);
        check("reset_out_valid", int'(data_out_valid), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("post_reset_in_ready", int'(data_in_ready), 1);
        check("post_reset_out_valid", int'(data_out_valid), 0);
        for (int i = 0; i < SZ; i++) check("post_reset_q", int'(data_out[i]), 0);
        check("post_reset_scale", int'(data_out_scale[0]), 0);
        @(posedge clk);
        #1;

        check("pin_3C00", model_q(16'h3C00, 15), 64);
        check("pin_BC00", model_q(16'hBC00, 15), -64);
        check("pin_3BFF", model_q(16'h3BFF, 14), 127);
        check("pin_3808", model_q(16'h3808, 14), 65);
        check("pin_B808", model_q(16'hB808, 14), -65);
        check("pin_1400", model_q(16'h1400, 14), 0);
        check("pin_3400", model_q(16'h3400, 16), 8);
        check("pin_0001", model_q(16'h0001, 0), 0);
        check("pin_scale14", model_scale(14), -7);
        check("pin_scale0", model_scale(0), 0);

        // Basic quantization
        send_row(mkrow(16'h3C00, 16'h3800, 16'hBC00, 16'h3400, 0, 0, 0, 0), RB, 1);
        check_first(64, 32, -64, 16, -6);
        wait_drain();

        // Saturation and rounding
        send_row(mkrow(16'h3BFF, 16'h3808, 16'hB808, 16'h1400,
                       16'h3800, 16'h3400, 16'h0000, 16'h3800), RB, 1);
        check_first(127, 65, -65, 0, -7);
        wait_drain();

        // Cross-beat maximum: 0.25 at scale 2^-5 is 8
        send_row(mkrow(16'h3400, 16'h3400, 16'h3400, 16'h3400, 16'h4000, 0, 0, 0), RB, 1);
        check_first(8, 8, 8, 8, -5);
        wait_drain();

        // Backpressure: 3 stalled cycles while the next row is offered
        data_out_ready = 1'b0;
        send_row(mkrow(16'h4400, 16'hC000, 16'h3C00, 16'h3555,
                       16'h4200, 16'h0000, 16'hB400, 16'h3E00), RB, 1);
        fork
            send_row(mkrow(16'h3800, 16'h3A00, 16'hB800, 16'h2C00,
                           16'h3000, 16'h3400, 16'h3600, 16'hBA00), RB, 1);
            begin
                repeat (3) @(posedge clk);
                #1;
                data_out_ready = 1'b1;
            end
        join
        wait_drain();

        // Reset mid-fill discards the partial row
        send_row(mkrow(16'h5C00, 16'h5C00, 16'h5C00, 16'h5C00, 0, 0, 0, 0), 1, 0);
        rst = 1'b1;
        @(negedge clk);
        check("mid_reset_in_ready", int'(data_in_ready), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        send_row(mkrow(16'h3C00, 16'h3800, 0, 0, 16'h3400, 0, 0, 0), RB, 1);
        check_first(64, 32, 0, 0, -6);
        wait_drain();

        // All-zero and subnormal row
        send_row(mkrow(16'h0000, 16'h0001, 16'h0000, 16'h0001,
                       16'h0001, 16'h0000, 16'h0001, 16'h0000), RB, 1);
        check_first(0, 0, 0, 0, 0);
        wait_drain();

        // Mixed exponents and signs, top-exponent saturation
        send_row(mkrow(16'hC500, 16'h4248, 16'h3A00, 16'hB0CD,
                       16'h2E66, 16'h4700, 16'h9000, 16'h0400), RB, 1);
        send_row(mkrow(16'h7800, 16'h3C00, 16'h0001, 16'hFBFF,
                       16'h5A00, 16'hDA00, 16'h0200, 16'h3C01), RB, 1);
        wait_drain();

        check("queue_empty", exp_data.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
